finish_collector: RTL and testbench

- Controller at the opposite end of the per-unit finish flags: drives the clear side of every processing unit's finish bit and reads back all flags.
- Per iteration:
  - clears all finish flags;
  - launches the processing units;
  - waits until every unit reports finish and the condition holds stable for a quiet window;
  - reports iteration completion to the host-side control logic.
- Sits between the host command/status registers and the array of per-PU finish bits.

---
 rtl/finish_collector_pkg.sv | 26 ++
 rtl/finish_collector_if.sv | 29 ++
 rtl/finish_quiet_timer.sv | 32 +++
 rtl/finish_collector.sv | 97 +++++++++
 tb/tb_finish_collector.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/finish_collector_pkg.sv
// Shared types and defaults for the finish-flag collection logic.
// Other control blocks reuse the default PU count and quiet window from here.
package finish_collector_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArm,
        StRun,
        StQuiet,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_NUM_PU       = 4;
    localparam int unsigned DEFAULT_QUIET_CYCLES = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/finish_collector_if.sv
// Host command/status and PU finish-flag signals of the finish collector.
// The master side is the host plus PU array; the slave side is the collector.
interface finish_collector_if #(
    parameter int unsigned NUM_PU = finish_collector_pkg::DEFAULT_NUM_PU,
    parameter int unsigned CNT_W  = 16
);

    logic              start;
    logic              abort;
    logic              host_ack;
    logic [NUM_PU-1:0] finish_in;
    logic              clear_finish;
    logic              pu_go;
    logic              busy;
    logic              iter_done;
    logic [NUM_PU-1:0] pending;
    logic [CNT_W-1:0]  iter_count;

    modport master (
        output start, abort, host_ack, finish_in,
        input  clear_finish, pu_go, busy, iter_done, pending, iter_count
    );

    modport slave (
        input  start, abort, host_ack, finish_in,
        output clear_finish, pu_go, busy, iter_done, pending, iter_count
    );

endinterface

// File: rtl/finish_quiet_timer.sv
// Counts consecutive all-finished cycles in QUIET; the collector FSM decides when to load/advance.
module finish_quiet_timer
    import finish_collector_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = DEFAULT_QUIET_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CntW    = clog2(QUIET_CYCLES) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(QUIET_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // Saturates at the last count so it never exceeds QUIET_CYCLES-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = (cnt_q == LastCnt);

endmodule

// File: rtl/finish_collector.sv
// Iteration controller: clears all PU finish flags, launches the PUs, waits for a
// stable all-finished window and reports completion to the host.
module finish_collector
    import finish_collector_pkg::*;
#(
    parameter int unsigned NUM_PU       = DEFAULT_NUM_PU,
    parameter int unsigned QUIET_CYCLES = DEFAULT_QUIET_CYCLES,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    finish_collector_if.slave bus
);

    state_e            state_q, state_d;
    logic              clear_q, go_q, busy_q, done_q;
    logic [NUM_PU-1:0] pending_q;
    logic [CNT_W-1:0]  count_q;
    logic              all_fin;
    logic              timer_load, timer_en, timer_expired;

    assign all_fin = &bus.finish_in;

    finish_quiet_timer #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quiet_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.start) state_d = StClear;
                StClear: state_d = StArm;
                StArm:   state_d = StRun;
                StRun: begin
                    if (all_fin) begin
                        state_d    = StQuiet;
                        timer_load = 1'b1;
                    end
                end
                StQuiet: begin
                    if (!all_fin)          state_d  = StRun;
                    else if (timer_expired) state_d = StDone;
                    else                    timer_en = 1'b1;
                end
                StDone:  if (bus.host_ack) state_d = bus.start ? StClear : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            clear_q   <= 1'b0;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            clear_q <= (state_d == StClear);
            go_q    <= (state_d == StArm);
            busy_q  <= (state_d inside {StClear, StArm, StRun, StQuiet});
            done_q  <= (state_d == StDone);
            // Only flags sampled while waiting, and still waiting, are reported.
            if ((state_q inside {StRun, StQuiet}) && (state_d inside {StRun, StQuiet})) begin
                pending_q <= ~bus.finish_in;
            end else begin
                pending_q <= '0;
            end
            if (state_q == StQuiet && state_d == StDone) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.clear_finish = clear_q;
    assign bus.pu_go        = go_q;
    assign bus.busy         = busy_q;
    assign bus.iter_done    = done_q;
    assign bus.pending      = pending_q;
    assign bus.iter_count   = count_q;

endmodule

// File: tb/tb_finish_collector.sv
// Bench for finish_collector: a wide-counter and a 2-bit-counter instance share stimulus
// and are compared each cycle against an all-high-streak model of the iteration rules.
module tb_finish_collector;

    localparam int unsigned NPU = 4;
    localparam int unsigned Q   = 4;

    typedef logic [33:0] snap_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   model_count = 0;

    finish_collector_if #(.NUM_PU(NPU), .CNT_W(16)) bus ();
    finish_collector_if #(.NUM_PU(NPU), .CNT_W(2))  bus_w ();

    assign bus_w.start     = bus.start;
    assign bus_w.abort     = bus.abort;
    assign bus_w.host_ack  = bus.host_ack;
    assign bus_w.finish_in = bus.finish_in;

    finish_collector #(.NUM_PU(NPU), .QUIET_CYCLES(Q), .CNT_W(16)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    finish_collector #(.NUM_PU(NPU), .QUIET_CYCLES(Q), .CNT_W(2)) dut_w (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_w)
    );

    always #5 clk = ~clk;

    function automatic snap_t observe();
        return {bus.clear_finish, bus.pu_go, bus.busy, bus.iter_done, bus.pending, bus.iter_count,
                bus_w.clear_finish, bus_w.pu_go, bus_w.busy, bus_w.iter_done, bus_w.pending,
                bus_w.iter_count};
    endfunction

    function automatic snap_t expect_snap(logic c, logic g, logic b, logic d, logic [3:0] p);
        return {c, g, b, d, p, 16'(model_count), c, g, b, d, p, 2'(model_count)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One iteration: launch, then feed pat[] (all-high once exhausted) during RUN/QUIET.
    task automatic iterate(input logic [3:0] pat[$], input bit from_done, input bit noise,
                           output int rise_cycle);
        int         streak;
        bit         done;
        logic [3:0] f;
        snap_t      obs, exp;
        streak     = 0;
        done       = 1'b0;
        rise_cycle = -1;
        bus.abort     = 1'b0;
        bus.start     = 1'b1;
        bus.host_ack  = from_done;
        bus.finish_in = 4'($urandom);
        tick();
        obs = observe(); exp = expect_snap(1, 0, 1, 0, 4'h0); total++;
        if (obs !== exp) begin bad++; $display("FAIL clear_pulse: got %h want %h", obs, exp); end
        bus.start     = noise ? 1'($urandom) : 1'b0;
        bus.host_ack  = noise ? 1'($urandom) : 1'b0;
        bus.finish_in = 4'($urandom);
        tick();
        obs = observe(); exp = expect_snap(0, 1, 1, 0, 4'h0); total++;
        if (obs !== exp) begin bad++; $display("FAIL go_pulse: got %h want %h", obs, exp); end
        bus.start     = noise ? 1'($urandom) : 1'b0;
        bus.host_ack  = noise ? 1'($urandom) : 1'b0;
        bus.finish_in = 4'($urandom);
        tick();
        obs = observe(); exp = expect_snap(0, 0, 1, 0, 4'h0); total++;
        if (obs !== exp) begin bad++; $display("FAIL run_entry: got %h want %h", obs, exp); end
        for (int k = 0; k < 200 && !done; k++) begin
            f = (k < pat.size()) ? pat[k] : 4'hF;
            bus.finish_in = f;
            bus.start     = noise ? 1'($urandom) : 1'b0;
            bus.host_ack  = noise ? 1'($urandom) : 1'b0;
            tick();
            streak = (f == 4'hF) ? streak + 1 : 0;
            if (streak == Q + 1) begin
                done = 1'b1;
                model_count++;
            end
            if (bus.iter_done === 1'b1 && rise_cycle < 0) rise_cycle = 4 + k;
            obs = observe(); exp = expect_snap(0, 0, !done, done, ~f); total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL run_cycle_%0d: got %h want %h", k, obs, exp);
            end
        end
        total++;
        if (rise_cycle < 0) begin bad++; $display("FAIL done_timeout: got no iter_done want one"); end
        bus.start    = 1'b0;
        bus.host_ack = 1'b0;
    endtask

    task automatic ack_to_idle();
        snap_t obs, exp;
        bus.start    = 1'b0;
        bus.host_ack = 1'b1;
        tick();
        obs = observe(); exp = expect_snap(0, 0, 0, 0, 4'h0); total++;
        if (obs !== exp) begin bad++; $display("FAIL ack_idle: got %h want %h", obs, exp); end
        bus.host_ack = 1'b0;
    endtask

    task automatic test_reset();
        snap_t obs, exp;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.host_ack  = 1'b0;
        bus.finish_in = 4'h0;
        model_count   = 0;
        tick();
        tick();
        obs = observe(); exp = expect_snap(0, 0, 0, 0, 4'h0); total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_state: got %h want %h", obs, exp); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] p[$];
        int         rise;
        p = {4'h0, 4'h0};
        iterate(p, 1'b0, 1'b0, rise);
        total++;
        if (rise !== 10) begin bad++; $display("FAIL basic_done_cycle: got %0d want 10", rise); end
        total++;
        if (bus.iter_count !== 16'd1) begin
            bad++;
            $display("FAIL basic_count: got %0d want 1", bus.iter_count);
        end
    endtask

    task automatic test_done_hold();
        snap_t obs, exp;
        for (int i = 0; i < 3; i++) begin
            bus.start     = 1'b1;
            bus.finish_in = 4'($urandom);
            tick();
            obs = observe(); exp = expect_snap(0, 0, 0, 1, 4'h0); total++;
            if (obs !== exp) begin bad++; $display("FAIL done_hold_%0d: got %h want %h", i, obs, exp); end
        end
        ack_to_idle();
        for (int i = 0; i < 3; i++) begin
            bus.host_ack = 1'b1;
            tick();
            obs = observe(); exp = expect_snap(0, 0, 0, 0, 4'h0); total++;
            if (obs !== exp) begin bad++; $display("FAIL idle_ack_%0d: got %h want %h", i, obs, exp); end
        end
        bus.host_ack = 1'b0;
    endtask

    task automatic test_glitch();
        logic [3:0] p[$];
        int         rise;
        p = {4'hF, 4'hF, 4'hF, 4'hD};
        iterate(p, 1'b0, 1'b0, rise);
        total++;
        if (rise !== 12) begin bad++; $display("FAIL glitch_done_cycle: got %0d want 12", rise); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p[$];
        int         rise;
        p = {4'h7, 4'hF, 4'hE};
        iterate(p, 1'b1, 1'b0, rise);
        iterate(p, 1'b1, 1'b0, rise);
    endtask

    task automatic test_abort();
        snap_t obs, exp;
        int    n_list[3];
        ack_to_idle();
        n_list = '{6, 7, int'($urandom_range(1, 7))};
        for (int t = 0; t < 3; t++) begin
            bus.start     = 1'b1;
            bus.finish_in = 4'hF;
            tick();
            bus.start = 1'b0;
            for (int c = 1; c < n_list[t]; c++) tick();
            bus.abort    = 1'b1;
            bus.start    = 1'b1;
            bus.host_ack = 1'b1;
            tick();
            obs = observe(); exp = expect_snap(0, 0, 0, 0, 4'h0); total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL abort_at_%0d: got %h want %h", n_list[t], obs, exp);
            end
            bus.abort    = 1'b0;
            bus.start    = 1'b0;
            bus.host_ack = 1'b0;
            for (int c = 0; c < 6; c++) begin
                tick();
                obs = observe(); total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL abort_idle_%0d_%0d: got %h want %h", n_list[t], c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] p[$];
        int         rise;
        snap_t      obs, exp;
        bus.start     = 1'b1;
        bus.finish_in = 4'h0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        obs = observe(); exp = expect_snap(0, 0, 1, 0, 4'hF); total++;
        if (obs !== exp) begin bad++; $display("FAIL pre_reset_run: got %h want %h", obs, exp); end
        #3;
        reset_n = 1'b0;
        model_count = 0;
        #1;
        obs = observe(); exp = expect_snap(0, 0, 0, 0, 4'h0); total++;
        if (obs !== exp) begin bad++; $display("FAIL async_reset: got %h want %h", obs, exp); end
        @(negedge clk);
        reset_n = 1'b1;
        p = {4'h1, 4'hF, 4'hB};
        iterate(p, 1'b0, 1'b0, rise);
    endtask

    task automatic test_random();
        logic [3:0] p[$];
        logic [3:0] v;
        int         rise;
        for (int it = 0; it < 6; it++) begin
            p = {};
            for (int j = 0; j < int'($urandom_range(3, 20)); j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = 4'($urandom);
                    if (v == 4'hF) v[$urandom_range(0, 3)] = 1'b0;
                end else begin
                    v = 4'hF;
                end
                p.push_back(v);
            end
            if ($urandom_range(0, 1) == 1) begin
                ack_to_idle();
                iterate(p, 1'b0, 1'b1, rise);
            end else begin
                iterate(p, 1'b1, 1'b1, rise);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] p[$];
        int         rise;
        int         want[4];
        want = '{1, 2, 3, 0};
        test_reset();
        p = {4'h3};
        for (int it = 0; it < 4; it++) begin
            iterate(p, it != 0, 1'b0, rise);
            total++;
            if (bus_w.iter_count !== 2'(want[it])) begin
                bad++;
                $display("FAIL wrap_%0d: got %0d want %0d", it, bus_w.iter_count, want[it]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_done_hold();
        test_glitch();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
